doorlock_ctrl_p: RTL and testbench

//  Parametrised door-lock control FSM; next generation of the single-user operational controller.

---
 rtl/doorlock_ctrl_p_if.sv | 13 +
 rtl/doorlock_ctrl_p.sv | 192 +++++++++++++++++++
 tb/tb_doorlock_ctrl_p.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/doorlock_ctrl_p_if.sv
// Keypad-to-lock PIN handoff.
//   pin_valid : 1-cycle strobe, pin_in holds a complete PIN
//   pin_in    : entered PIN, digit1 in the MSBs
// master = keypad front end (driver), slave = lock controller (receiver).
interface doorlock_ctrl_p_if #(
    parameter int N_DIGITS = 4
);
    logic                  pin_valid;
    logic [4*N_DIGITS-1:0] pin_in;

    modport master (output pin_valid, output pin_in);
    modport slave  (input  pin_valid, input  pin_in);
endinterface

// File: rtl/doorlock_ctrl_p.sv
// Door-lock sequencing FSM. Checks keypad PINs against a master PIN and a
// table of user PINs. Adds an escalating lockout after wrong PINs, an alarm
// state (fail limit or forced door) and auto-relock / door-open buzzer timers
// driven by an internal ms prescaler.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   sensor_de_contato      1 = door closed
//   botao_interno          inside lock/unlock button (level)
//   keypad                 PIN strobe + value (doorlock_ctrl_p_if.slave)
//   master_pin, user_pins  PIN table, user slot 0 in the LSBs
//   user_en                per-slot enable
//   bip_en, bip_time       door-open buzzer enable and delay (ms)
//   lock_time              auto-relock delay (ms), 0 = off
//   setup_end              setup block finished
//   tranca, bip, alarm     bolt, buzzer, alarm indicator
//   setup_on, bcd_enable   setup block active, keypad display enable
//   fail_cnt, user_id      consecutive fails, last matched slot+1 (0 = none)
//
// state    | meaning
// INIT     | after reset, waits for door closed
// LOCKED   | bolt engaged, accepting PINs
// CHECK    | one cycle: compare latched PIN
// WAIT     | lockout after a wrong PIN, PINs ignored
// UNLOCKED | bolt released, door still closed
// OPEN     | door open, buzzer after bip_time
// SETUP    | setup block owns the keypad
// ALARM    | fail limit or forced door; master PIN only
module doorlock_ctrl_p #(
    parameter int N_USERS      = 4,
    parameter int N_DIGITS     = 4,
    parameter int TICKS_PER_MS = 1,
    parameter int TIME_W       = 16,
    parameter int MAX_FAIL     = 5,
    parameter int WAIT_BASE_MS = 1000,
    parameter int WAIT_MAX_MS  = 30000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sensor_de_contato,
    input  logic                            botao_interno,
    doorlock_ctrl_p_if.slave                keypad,
    input  logic [4*N_DIGITS-1:0]           master_pin,
    input  logic [4*N_DIGITS*N_USERS-1:0]   user_pins,
    input  logic [N_USERS-1:0]              user_en,
    input  logic                            bip_en,
    input  logic [TIME_W-1:0]               bip_time,
    input  logic [TIME_W-1:0]               lock_time,
    input  logic                            setup_end,
    output logic                            tranca,
    output logic                            bip,
    output logic                            alarm,
    output logic                            setup_on,
    output logic                            bcd_enable,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic [3:0]                      user_id
);
    localparam int W  = 4 * N_DIGITS;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int WW = TIME_W + MAX_FAIL;
    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    typedef enum logic [2:0] {
        S_INIT, S_LOCKED, S_CHECK, S_WAIT, S_UNLOCKED, S_OPEN, S_SETUP, S_ALARM
    } state_t;

    state_t            state, state_next;
    logic [PW-1:0]     presc;
    logic              ms_tick;
    logic [TIME_W-1:0] timer;
    logic [TIME_W-1:0] wait_ms;
    logic [W-1:0]      pin_reg;

    logic              master_hit, user_hit, alarm_clear;
    logic [3:0]        user_idx;
    logic [FW-1:0]     fail_new;
    logic [WW-1:0]     wait_wide;
    logic [TIME_W-1:0] wait_calc;

    assign ms_tick = (presc == PW'(TICKS_PER_MS - 1));

    always_comb begin
        state_next  = state;
        tranca      = 1'b0;
        bip         = 1'b0;
        alarm       = 1'b0;
        setup_on    = 1'b0;
        bcd_enable  = 1'b0;
        master_hit  = (pin_reg == master_pin);
        alarm_clear = keypad.pin_valid && (keypad.pin_in == master_pin);
        user_hit    = 1'b0;
        user_idx    = '0;
        // Scan downward so the lowest matching slot wins.
        for (int k = N_USERS - 1; k >= 0; k--) begin
            if (user_en[k] && (user_pins[k*W +: W] == pin_reg)) begin
                user_hit = 1'b1;
                user_idx = 4'(k);
            end
        end
        fail_new  = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;
        // Wide shift so large fail counts saturate instead of wrapping.
        wait_wide = WW'(WAIT_BASE_MS) << (fail_new - 1'b1);
        wait_calc = (wait_wide > WW'(WAIT_MAX_MS)) ? TIME_W'(WAIT_MAX_MS)
                                                   : wait_wide[TIME_W-1:0];

        case (state)
            S_INIT: begin
                if (sensor_de_contato) state_next = S_LOCKED;
            end
            S_LOCKED: begin
                tranca     = 1'b1;
                bcd_enable = 1'b1;
                if (botao_interno)          state_next = S_UNLOCKED;
                else if (!sensor_de_contato) state_next = S_ALARM;
                else if (keypad.pin_valid)  state_next = S_CHECK;
            end
            S_CHECK: begin
                tranca     = 1'b1;
                bcd_enable = 1'b1;
                if (master_hit)                  state_next = S_SETUP;
                else if (user_hit)               state_next = S_UNLOCKED;
                else if (fail_new >= FW'(MAX_FAIL)) state_next = S_ALARM;
                else                             state_next = S_WAIT;
            end
            S_WAIT: begin
                tranca     = 1'b1;
                bcd_enable = 1'b1;
                if (botao_interno)        state_next = S_UNLOCKED;
                else if (timer == wait_ms) state_next = S_LOCKED;
            end
            S_UNLOCKED: begin
                if (!sensor_de_contato) state_next = S_OPEN;
                else if (botao_interno ||
                         ((lock_time != '0) && (timer >= lock_time)))
                    state_next = S_LOCKED;
            end
            S_OPEN: begin
                bip = bip_en && (timer >= bip_time);
                if (sensor_de_contato) state_next = S_UNLOCKED;
            end
            S_SETUP: begin
                setup_on = 1'b1;
                tranca   = 1'b1;
                if (setup_end) state_next = S_LOCKED;
            end
            S_ALARM: begin
                alarm      = 1'b1;
                bip        = 1'b1;
                tranca     = 1'b1;
                bcd_enable = 1'b1;
                if (alarm_clear) state_next = S_LOCKED;
            end
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            presc    <= '0;
            timer    <= '0;
            wait_ms  <= '0;
            pin_reg  <= '0;
            fail_cnt <= '0;
            user_id  <= '0;
        end else begin
            state <= state_next;
            presc <= ms_tick ? '0 : presc + 1'b1;
            if (state_next != state)
                timer <= '0;
            else if (ms_tick && (timer != '1))
                timer <= timer + 1'b1;
            if (state == S_LOCKED && state_next == S_CHECK)
                pin_reg <= keypad.pin_in;
            case (state)
                S_CHECK: begin
                    if (master_hit) begin
                        fail_cnt <= '0;
                    end else if (user_hit) begin
                        fail_cnt <= '0;
                        user_id  <= user_idx + 4'd1;
                    end else begin
                        fail_cnt <= fail_new;
                        wait_ms  <= wait_calc;
                    end
                end
                S_UNLOCKED: fail_cnt <= '0;
                S_ALARM:    if (alarm_clear) fail_cnt <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_doorlock_ctrl_p.sv
// Bench for doorlock_ctrl_p: directed vector table, timed sequences for the
// lockout / relock / buzzer corners, then random stimulus. A behavioural
// model (elapsed-time arithmetic, PIN table search) is compared every cycle.
module tb_doorlock_ctrl_p;
    localparam int MAX_FAIL = 5;
    localparam int WB = 1000;
    localparam int WM = 30000;
    localparam int MI = 0, ML = 1, MC = 2, MW = 3, MU = 4, MO = 5, MS = 6, MA = 7;
    localparam logic [4:0] O_LK = 5'b10001, O_UN = 5'b00000;
    localparam logic [4:0] O_SU = 5'b10010, O_AL = 5'b11101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sensor, botao, bip_en, setup_end;
    logic [15:0] master_pin, bip_time, lock_time;
    logic [63:0] user_pins;
    logic [3:0]  user_en;
    logic        tranca, bip, alarm, setup_on, bcd_enable;
    logic [2:0]  fail_cnt;
    logic [3:0]  user_id;

    doorlock_ctrl_p_if #(.N_DIGITS(4)) kp();

    doorlock_ctrl_p #(
        .N_USERS(4), .N_DIGITS(4), .TICKS_PER_MS(1), .TIME_W(16),
        .MAX_FAIL(MAX_FAIL), .WAIT_BASE_MS(WB), .WAIT_MAX_MS(WM)
    ) dut (
        .clk(clk), .rst(rst), .sensor_de_contato(sensor), .botao_interno(botao),
        .keypad(kp), .master_pin(master_pin), .user_pins(user_pins),
        .user_en(user_en), .bip_en(bip_en), .bip_time(bip_time),
        .lock_time(lock_time), .setup_end(setup_end), .tranca(tranca), .bip(bip),
        .alarm(alarm), .setup_on(setup_on), .bcd_enable(bcd_enable),
        .fail_cnt(fail_cnt), .user_id(user_id)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode = MI;
    int          m_entry = 0;
    int          cyc = 0;
    int          m_fail = 0;
    int          m_uid = 0;
    int          m_wait = 0;
    logic [15:0] m_pin = '0;

    function automatic int pin_slot(input logic [15:0] p);
        for (int k = 0; k < 4; k++)
            if (user_en[k] && user_pins[k*16 +: 16] == p) return k;
        return -1;
    endfunction

    function automatic int elapsed();
        int e;
        e = cyc - m_entry;
        return (e > 65535) ? 65535 : e;
    endfunction

    task automatic model_edge();
        int el, nm, k;
        el = elapsed();
        nm = m_mode;
        if (rst) begin
            nm = MI; m_fail = 0; m_uid = 0;
        end else begin
            case (m_mode)
                MI: if (sensor) nm = ML;
                ML: begin
                    if (botao) nm = MU;
                    else if (!sensor) nm = MA;
                    else if (kp.pin_valid) begin nm = MC; m_pin = kp.pin_in; end
                end
                MC: begin
                    k = pin_slot(m_pin);
                    if (m_pin == master_pin) begin
                        nm = MS; m_fail = 0;
                    end else if (k >= 0) begin
                        nm = MU; m_uid = k + 1; m_fail = 0;
                    end else begin
                        m_fail = (m_fail < MAX_FAIL) ? m_fail + 1 : MAX_FAIL;
                        if (m_fail >= MAX_FAIL) nm = MA;
                        else begin
                            nm = MW;
                            m_wait = WB * (1 << (m_fail - 1));
                            if (m_wait > WM) m_wait = WM;
                        end
                    end
                end
                MW: begin
                    if (botao) nm = MU;
                    else if (el == m_wait) nm = ML;
                end
                MU: begin
                    m_fail = 0;
                    if (!sensor) nm = MO;
                    else if (botao) nm = ML;
                    else if (lock_time != 0 && el >= int'(lock_time)) nm = ML;
                end
                MO: if (sensor) nm = MU;
                MS: if (setup_end) nm = ML;
                MA: if (kp.pin_valid && kp.pin_in == master_pin) begin nm = ML; m_fail = 0; end
                default: nm = MI;
            endcase
        end
        cyc++;
        if (rst || nm != m_mode) m_entry = cyc;
        m_mode = nm;
    endtask

    task automatic compare_model();
        logic tr, bp, al, su, bc;
        tr = (m_mode == ML || m_mode == MC || m_mode == MW || m_mode == MS || m_mode == MA);
        bc = (m_mode == ML || m_mode == MC || m_mode == MW || m_mode == MA);
        al = (m_mode == MA);
        su = (m_mode == MS);
        bp = (m_mode == MA) || (m_mode == MO && bip_en && elapsed() >= int'(bip_time));
        check("model", {20'd0, tranca, bip, alarm, setup_on, bcd_enable, fail_cnt, user_id},
              {20'd0, tr, bp, al, su, bc, 3'(m_fail), 4'(m_uid)});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    function automatic bit cond(input int what, input int val);
        case (what)
            0:       return tranca == val[0];
            1:       return bip == val[0];
            default: return int'(fail_cnt) == val;
        endcase
    endfunction

    task automatic wait_for(input int what, input int val, input int budget, output int n);
        n = 0;
        while (n < budget && !cond(what, val)) begin
            step();
            n++;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        b, s, p;
        logic [15:0] pin;
        logic        se;
        logic [3:0]  uen;
        int          idle;
        logic [4:0]  outs;   // {tranca, bip, alarm, setup_on, bcd_enable}
        int          fail;
        int          uid;
    } vec_t;

    function automatic vec_t mk(input logic b, s, p, input logic [15:0] pin, input logic se,
                                input logic [3:0] uen, input int idle, input logic [4:0] outs,
                                input int fail, input int uid);
        vec_t v;
        v.b = b; v.s = s; v.p = p; v.pin = pin; v.se = se; v.uen = uen;
        v.idle = idle; v.outs = outs; v.fail = fail; v.uid = uid;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int n, idx, r;
        vecs.push_back(mk(0,1,0,16'h0000,0,4'hF,0,O_LK,0,0)); // INIT -> LOCKED
        vecs.push_back(mk(0,1,1,16'h3333,0,4'hF,0,O_LK,0,0)); // CHECK
        vecs.push_back(mk(0,1,0,16'h0000,0,4'hF,0,O_UN,0,3)); // slot2 -> UNLOCKED
        vecs.push_back(mk(1,1,0,16'h0000,0,4'hF,0,O_LK,0,3));
        vecs.push_back(mk(0,1,1,16'h2222,0,4'hF,1,O_UN,0,2)); // lowest slot wins
        vecs.push_back(mk(1,1,0,16'h0000,0,4'hF,0,O_LK,0,2));
        vecs.push_back(mk(0,1,1,16'h2222,0,4'hD,1,O_UN,0,4)); // slot1 disabled
        vecs.push_back(mk(1,1,0,16'h0000,0,4'hD,0,O_LK,0,4));
        vecs.push_back(mk(0,1,1,16'h3333,0,4'hB,1,O_LK,1,4)); // disabled slot -> WAIT
        vecs.push_back(mk(1,1,0,16'h0000,0,4'hB,0,O_UN,1,4)); // button escapes WAIT
        vecs.push_back(mk(0,1,0,16'h0000,0,4'hF,0,O_UN,0,4)); // fail clears in UNLOCKED
        vecs.push_back(mk(1,1,0,16'h0000,0,4'hF,0,O_LK,0,4));
        vecs.push_back(mk(0,0,0,16'h0000,0,4'hF,0,O_AL,0,4)); // forced door
        vecs.push_back(mk(0,0,1,16'h9999,0,4'hF,0,O_AL,0,4)); // wrong PIN not counted
        vecs.push_back(mk(0,1,1,16'h1234,0,4'hF,0,O_LK,0,4)); // master clears alarm
        vecs.push_back(mk(1,1,1,16'h1111,0,4'hF,2,O_UN,0,4)); // button beats PIN
        vecs.push_back(mk(0,0,0,16'h0000,0,4'hF,0,O_UN,0,4)); // OPEN, bip not yet
        vecs.push_back(mk(0,1,0,16'h0000,0,4'hF,0,O_UN,0,4));
        vecs.push_back(mk(1,1,0,16'h0000,0,4'hF,0,O_LK,0,4));
        vecs.push_back(mk(0,1,1,16'h1234,0,4'hF,1,O_SU,0,4)); // master -> SETUP
        vecs.push_back(mk(0,1,1,16'h1111,0,4'hF,1,O_SU,0,4)); // PIN ignored in SETUP
        vecs.push_back(mk(0,1,0,16'h0000,1,4'hF,0,O_LK,0,4)); // setup_end
        vecs.push_back(mk(0,1,1,16'h9999,0,4'hF,1,O_LK,1,4)); // -> WAIT

        rst = 1; sensor = 0; botao = 0; bip_en = 1; setup_end = 0;
        master_pin = 16'h1234; user_pins = {16'h2222, 16'h3333, 16'h2222, 16'h1111};
        user_en = 4'hF; bip_time = 16'd200; lock_time = 16'd0;
        kp.pin_valid = 0; kp.pin_in = '0;
        step(); step();
        check("reset_outs", {tranca, bip, alarm, setup_on, bcd_enable, fail_cnt, user_id}, 12'd0);
        rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            botao = vecs[i].b; sensor = vecs[i].s; kp.pin_valid = vecs[i].p;
            kp.pin_in = vecs[i].pin; setup_end = vecs[i].se; user_en = vecs[i].uen;
            step();
            botao = 0; kp.pin_valid = 0; setup_end = 0;
            repeat (vecs[i].idle) step();
            check($sformatf("vec%0d_outs", i), {tranca, bip, alarm, setup_on, bcd_enable}, vecs[i].outs);
            check($sformatf("vec%0d_fail", i), fail_cnt, vecs[i].fail);
            check($sformatf("vec%0d_uid", i), user_id, vecs[i].uid);
        end

        // reset in the middle of WAIT
        rst = 1; step();
        check("rst_mid_wait", {tranca, bip, alarm, setup_on, bcd_enable, fail_cnt, user_id}, 12'd0);
        rst = 0; step();
        check("relock_after_rst", {tranca, bip, alarm, setup_on, bcd_enable}, O_LK);

        // escalating lockout with PIN held valid (early strobes must be ignored)
        bip_en = 0; kp.pin_in = 16'h9999; kp.pin_valid = 1;
        wait_for(2, 1, 100, n);   check("lockout_f1", n, 2);
        wait_for(2, 2, 1500, n);  check("lockout_1000", n, 1003);
        wait_for(2, 3, 2500, n);  check("lockout_2000", n, 2003);
        wait_for(2, 4, 4500, n);  check("lockout_4000", n, 4003);
        wait_for(2, 5, 9000, n);  check("lockout_8000", n, 8003);
        check("alarm_outs", {tranca, bip, alarm, setup_on, bcd_enable}, O_AL);
        repeat (3) step();
        check("alarm_wrong_pin_fail", fail_cnt, 5);
        check("alarm_wrong_pin_alarm", alarm, 1);
        kp.pin_in = 16'h1234; step(); kp.pin_valid = 0;
        check("alarm_master_outs", {tranca, bip, alarm, setup_on, bcd_enable}, O_LK);
        check("alarm_master_fail", fail_cnt, 0);

        // auto relock, door-open buzzer, timer restart on close
        bip_en = 1; bip_time = 16'd200; lock_time = 16'd5000;
        kp.pin_in = 16'h1111; kp.pin_valid = 1; step(); kp.pin_valid = 0; step();
        check("unlock_slot0", user_id, 1);
        wait_for(0, 1, 6000, n);  check("relock_5000", n, 5001);
        botao = 1; step(); botao = 0;
        sensor = 0; step();
        wait_for(1, 1, 500, n);   check("bip_200", n, 200);
        sensor = 1; step();
        check("close_outs", {tranca, bip, alarm, setup_on, bcd_enable}, O_UN);
        wait_for(0, 1, 6000, n);  check("relock_restart", n, 5001);

        // bip_time = 0 buzzes from the first OPEN cycle; bip_en gates it
        lock_time = 16'd0; bip_time = 16'd0;
        botao = 1; step(); botao = 0;
        sensor = 0; step();
        check("bip_time0", bip, 1);
        bip_en = 0; #1;
        check("bip_en_off", bip, 0);
        sensor = 1; step(); botao = 1; step(); botao = 0;
        bip_en = 1;

        // random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                user_en   = 4'($urandom);
                lock_time = 16'($urandom_range(0, 30));
                bip_time  = 16'($urandom_range(0, 15));
                bip_en    = 1'($urandom);
            end
            rst       = ($urandom_range(0, 499) == 0);
            botao     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) sensor = ~sensor;
            setup_end = ($urandom_range(0, 7) == 0);
            kp.pin_valid = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 2);
            idx = $urandom_range(0, 3);
            case (r)
                0:       kp.pin_in = master_pin;
                1:       kp.pin_in = user_pins[idx*16 +: 16];
                default: kp.pin_in = 16'($urandom);
            endcase
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
